// File: rtl/nway_sa_cache.sv
// N-way set-associative write-back cache, true-LRU, line-wide memory handshake; optional counters under NWAY_SA_CACHE_STATS_EN.
// Latency: hit responds 2 cycles after accept; miss responds 1 cycle after the final i_mem_ack.
// Backpressure: o_req_ready only in IDLE (one request in flight); memory stalls hold via i_mem_ack; responses never stall.
module nway_sa_cache #(
  parameter int WAYS       = 4,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 16,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic                         i_we,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic                         o_resp_valid,
  output logic [DATA_W-1:0]            o_rdata,
  output logic                         o_hit,
  output logic                         o_miss,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [LINE_WORDS*DATA_W-1:0] o_mem_wdata,
  input  logic                         i_mem_ack,
  input  logic [LINE_WORDS*DATA_W-1:0] i_mem_rdata
`ifdef NWAY_SA_CACHE_STATS_EN
  ,
  output logic [31:0]                  o_hit_count,
  output logic [31:0]                  o_miss_count
`endif
);

  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int WAY_W  = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, REFILL, RESP} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic              valid_q [WAYS][SETS];
  logic              dirty_q [WAYS][SETS];
  logic [WAY_W-1:0]  age_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];

  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              hit_q;
  logic [WAY_W-1:0]  vict_q;
  logic [DATA_W-1:0] rdata_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WORD_W-1:0] req_word;
  logic              unused_addr_bits;
  logic              mem_fire;

  assign req_idx          = req_addr[OFF_W +: IDX_W];
  assign req_tag          = req_addr[ADDR_W-1 -: TAG_W];
  assign req_word         = req_addr[BYTE_W +: WORD_W];
  assign unused_addr_bits = ^req_addr[BYTE_W-1:0];
  // An ack outside an active request is meaningless and dropped here.
  assign mem_fire         = o_mem_req & i_mem_ack;

  logic             hit, inv_found, victim_dirty;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim;

  // Parallel tag compare plus victim choice: lowest invalid way, else the oldest.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][req_idx] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[w][req_idx] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
  end

  assign victim       = inv_found ? inv_way : lru_way;
  assign victim_dirty = valid_q[victim][req_idx] && dirty_q[victim][req_idx];

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_W-1:0] idx,
                                                   input logic [DATA_W-1:0] word);
    logic [LINE_W-1:0] m;
    m = line;
    m[idx*DATA_W +: DATA_W] = word;
    return m;
  endfunction

  logic              upd, fill, line_wr;
  logic [WAY_W-1:0]  upd_way;
  logic [LINE_W-1:0] line_wdata;

  // Next-state and array-commit decode.
  always_comb begin
    state_nxt  = state;
    upd        = 1'b0;
    upd_way    = '0;
    fill       = 1'b0;
    line_wr    = 1'b0;
    line_wdata = '0;
    case (state)
      IDLE: if (i_req_valid) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          state_nxt = RESP;
          upd       = 1'b1;
          upd_way   = hit_way;
          if (req_we) begin
            line_wr    = 1'b1;
            line_wdata = merge_word(data_q[hit_way][req_idx], req_word, req_wdata);
          end
        end else begin
          state_nxt = victim_dirty ? EVICT : REFILL;
        end
      end
      EVICT: if (mem_fire) state_nxt = REFILL;
      REFILL: begin
        if (mem_fire) begin
          state_nxt  = RESP;
          upd        = 1'b1;
          upd_way    = vict_q;
          fill       = 1'b1;
          line_wr    = 1'b1;
          line_wdata = req_we ? merge_word(i_mem_rdata, req_word, req_wdata) : i_mem_rdata;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_req_ready  = (state == IDLE);
  assign o_resp_valid = (state == RESP);
  assign o_hit        = (state == RESP) && hit_q;
  assign o_rdata      = (state == RESP) ? rdata_q : '0;
  assign o_miss       = (state == LOOKUP) && !hit;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Line data storage; not reset, validity is tracked separately.
  always_ff @(posedge clk) begin
    if (line_wr) data_q[upd_way][req_idx] <= line_wdata;
  end

  // Tag/valid/dirty and LRU ages; the accessed way goes to 0, younger ways age by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s]   <= '0;
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          age_q[w][s]   <= WAY_W'(w);
        end
      end
    end else if (upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way)
          age_q[w][req_idx] <= '0;
        else if (age_q[w][req_idx] < age_q[upd_way][req_idx])
          age_q[w][req_idx] <= age_q[w][req_idx] + 1'b1;
      end
      if (fill) begin
        valid_q[upd_way][req_idx] <= 1'b1;
        tag_q[upd_way][req_idx]   <= req_tag;
      end
      if (req_we)    dirty_q[upd_way][req_idx] <= 1'b1;
      else if (fill) dirty_q[upd_way][req_idx] <= 1'b0;
    end
  end

  // Request latch, response data and registered memory-side handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr    <= '0;
      req_we      <= 1'b0;
      req_wdata   <= '0;
      hit_q       <= 1'b0;
      vict_q      <= '0;
      rdata_q     <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            req_addr  <= i_addr;
            req_we    <= i_we;
            req_wdata <= i_wdata;
          end
        end
        LOOKUP: begin
          hit_q  <= hit;
          vict_q <= victim;
          if (hit) begin
            rdata_q <= req_we ? '0 : data_q[hit_way][req_idx][req_word*DATA_W +: DATA_W];
          end else if (victim_dirty) begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b1;
            o_mem_addr  <= {tag_q[victim][req_idx], req_idx, {OFF_W{1'b0}}};
            o_mem_wdata <= data_q[victim][req_idx];
          end
        end
        EVICT: if (mem_fire) o_mem_req <= 1'b0;
        REFILL: begin
          // First REFILL cycle is idle so the bus shows a gap after a writeback.
          if (mem_fire) begin
            o_mem_req <= 1'b0;
            rdata_q   <= req_we ? '0 : i_mem_rdata[req_word*DATA_W +: DATA_W];
          end else if (!o_mem_req) begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
            o_mem_wdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NWAY_SA_CACHE_STATS_EN
  // Saturating hit/miss counters, counted in the lookup cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit && (o_hit_count != '1))   o_hit_count  <= o_hit_count + 1'b1;
      if (!hit && (o_miss_count != '1)) o_miss_count <= o_miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nway_sa_cache.sv
module tb_nway_sa_cache;
  localparam int LINE_W = 512;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_req_valid = 1'b0;
  logic              o_req_ready;
  logic [31:0]       i_addr = '0;
  logic              i_we = 1'b0;
  logic [31:0]       i_wdata = '0;
  logic              o_resp_valid;
  logic [31:0]       o_rdata;
  logic              o_hit;
  logic              o_miss;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [31:0]       o_mem_addr;
  logic [LINE_W-1:0] o_mem_wdata;
  logic              i_mem_ack = 1'b0;
  logic [LINE_W-1:0] i_mem_rdata = '0;
`ifdef NWAY_SA_CACHE_STATS_EN
  logic [31:0]       o_hit_count;
  logic [31:0]       o_miss_count;
`endif

  nway_sa_cache dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_addr(i_addr), .i_we(i_we), .i_wdata(i_wdata),
    .o_resp_valid(o_resp_valid), .o_rdata(o_rdata), .o_hit(o_hit), .o_miss(o_miss),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
`ifdef NWAY_SA_CACHE_STATS_EN
    , .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
  } resp_t;

  typedef struct {
    logic              we;
    logic [31:0]       addr;
    logic [LINE_W-1:0] line;
    int                stall;
    logic              abort_ok;
  } mem_t;

  resp_t resp_q[$];
  mem_t  mem_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int resp_seen = 0;
  int acc_cyc = 0;
  int last_ack_cyc = 0;
  int miss_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (o_miss) begin
        miss_seen++;
        check("miss_ready_low", 64'(o_req_ready), 64'(0));
      end
      if (o_resp_valid) begin
        if (resp_q.size() == 0) begin
          fail("unexpected_response");
        end else begin
          e = resp_q.pop_front();
          check("rdata", 64'(o_rdata), 64'(e.rdata));
          check("hit", 64'(o_hit), 64'(e.hit));
          check("miss_pulse", 64'(miss_seen != 0), 64'(!e.hit));
          check("resp_ready_low", 64'(o_req_ready), 64'(0));
          if (e.hit) check("hit_latency", 64'(cyc - acc_cyc), 64'(1));
          else       check("miss_latency", 64'(cyc - last_ack_cyc), 64'(1));
        end
        miss_seen = 0;
        resp_seen++;
      end
    end
  end

  // Memory responder: checks each request against the expected queue, stalls, then acks.
  initial begin
    mem_t m;
    logic [31:0] a0;
    logic        w0;
    logic        aborted;
    forever begin
      @(negedge clk);
      if (rst && o_mem_req) begin
        if (mem_q.size() == 0) begin
          fail("unexpected_mem_req");
          m.we = o_mem_we; m.addr = o_mem_addr; m.line = '0; m.stall = 0; m.abort_ok = 1'b0;
        end else begin
          m = mem_q.pop_front();
        end
        check("mem_we", 64'(o_mem_we), 64'(m.we));
        check("mem_addr", 64'(o_mem_addr), 64'(m.addr));
        if (m.we) check_line("wb_line", o_mem_wdata, m.line);
        a0 = o_mem_addr;
        w0 = o_mem_we;
        aborted = 1'b0;
        for (int i = 0; i < m.stall; i++) begin
          @(negedge clk);
          if (!o_mem_req) begin
            if (!m.abort_ok) fail("mem_req_dropped");
            aborted = 1'b1;
            break;
          end
          check("stall_addr", 64'(o_mem_addr), 64'(a0));
          check("stall_we", 64'(o_mem_we), 64'(w0));
          check("stall_ready_low", 64'(o_req_ready), 64'(0));
        end
        if (!aborted) begin
          i_mem_ack = 1'b1;
          if (!m.we) i_mem_rdata = m.line;
          last_ack_cyc = cyc;
          @(negedge clk);
          i_mem_ack = 1'b0;
          check("mem_req_gap", 64'(o_mem_req), 64'(0));
        end
      end
    end
  end

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [LINE_W-1:0] line,
                         input int stall, input logic abort_ok);
    mem_t m;
    m.we = we; m.addr = addr; m.line = line; m.stall = stall; m.abort_ok = abort_ok;
    mem_q.push_back(m);
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_req_ready) fail("req_ready_timeout");
    i_req_valid = 1'b1;
    i_addr = addr;
    i_we = we;
    i_wdata = wdata;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    i_req_valid = 1'b0;
    i_we = 1'b0;
    i_wdata = '0;
  endtask

  task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_hit);
    resp_t r;
    int target;
    int n = 0;
    r.rdata = exp_rdata;
    r.hit = exp_hit;
    resp_q.push_back(r);
    target = resp_seen + 1;
    issue(addr, we, wdata);
    while (resp_seen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (resp_seen < target) fail("resp_timeout");
  endtask

  initial begin
    logic [LINE_W-1:0] wb;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(o_req_ready), 64'(1));
    check("rst_mem_req", 64'(o_mem_req), 64'(0));
    check("rst_resp_valid", 64'(o_resp_valid), 64'(0));
    check("rst_miss", 64'(o_miss), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Cold read then hit on the same line
    exp_mem(1'b0, 32'h0000_0040, mk_line(32'h1111_1111), 2, 1'b0);
    access(32'h0000_0040, 1'b0, '0, 32'h1111_1111, 1'b0);
    access(32'h0000_0044, 1'b0, '0, 32'h1111_1112, 1'b1);

    // Dirty eviction in set 0
    exp_mem(1'b0, 32'h0000_0000, mk_line(32'hA000_0000), 2, 1'b0);
    access(32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
    exp_mem(1'b0, 32'h0000_4000, mk_line(32'hB100_0000), 1, 1'b0);
    access(32'h0000_4000, 1'b0, '0, 32'hB100_0000, 1'b0);
    exp_mem(1'b0, 32'h0000_8000, mk_line(32'hB200_0000), 1, 1'b0);
    access(32'h0000_8000, 1'b0, '0, 32'hB200_0000, 1'b0);
    exp_mem(1'b0, 32'h0000_C000, mk_line(32'hB300_0000), 1, 1'b0);
    access(32'h0000_C000, 1'b0, '0, 32'hB300_0000, 1'b0);
    wb = mk_line(32'hA000_0000);
    wb[31:0] = 32'hDEAD_BEEF;
    exp_mem(1'b1, 32'h0000_0000, wb, 3, 1'b0);
    exp_mem(1'b0, 32'h0001_0000, mk_line(32'hB400_0000), 1, 1'b0);
    access(32'h0001_0000, 1'b0, '0, 32'hB400_0000, 1'b0);

    // LRU order in set 5, with a 10-cycle memory stall on the T4 refill
    exp_mem(1'b0, 32'h0000_0140, mk_line(32'hC000_0000), 1, 1'b0);
    access(32'h0000_0140, 1'b0, '0, 32'hC000_0000, 1'b0);
    exp_mem(1'b0, 32'h0000_4140, mk_line(32'hC100_0000), 1, 1'b0);
    access(32'h0000_4140, 1'b0, '0, 32'hC100_0000, 1'b0);
    exp_mem(1'b0, 32'h0000_8140, mk_line(32'hC200_0000), 1, 1'b0);
    access(32'h0000_8140, 1'b0, '0, 32'hC200_0000, 1'b0);
    exp_mem(1'b0, 32'h0000_C140, mk_line(32'hC300_0000), 1, 1'b0);
    access(32'h0000_C140, 1'b0, '0, 32'hC300_0000, 1'b0);
    access(32'h0000_017C, 1'b0, '0, 32'hC000_000F, 1'b1);
    exp_mem(1'b0, 32'h0001_0140, mk_line(32'hC400_0000), 10, 1'b0);
    access(32'h0001_0140, 1'b0, '0, 32'hC400_0000, 1'b0);
    access(32'h0000_0140, 1'b0, '0, 32'hC000_0000, 1'b1);
    exp_mem(1'b0, 32'h0000_4140, mk_line(32'hC500_0000), 1, 1'b0);
    access(32'h0000_4140, 1'b0, '0, 32'hC500_0000, 1'b0);

    // Write hit then read back
    access(32'h0000_0144, 1'b1, 32'h1234_5678, 32'h0, 1'b1);
    access(32'h0000_0144, 1'b0, '0, 32'h1234_5678, 1'b1);

    // Reset during a refill
    exp_mem(1'b0, 32'h8000_0000, '0, 1000, 1'b1);
    issue(32'h8000_0000, 1'b0, '0);
    n = 0;
    while (!o_mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_mem_req) fail("refill_req_timeout");
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_mem_req", 64'(o_mem_req), 64'(0));
    check("rst_mid_ready", 64'(o_req_ready), 64'(1));
    check("rst_mid_resp_valid", 64'(o_resp_valid), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    miss_seen = 0;
    exp_mem(1'b0, 32'h8000_0000, mk_line(32'hE000_0000), 2, 1'b0);
    access(32'h8000_0000, 1'b0, '0, 32'hE000_0000, 1'b0);
    exp_mem(1'b0, 32'h0000_0040, mk_line(32'hE100_0000), 2, 1'b0);
    access(32'h0000_0044, 1'b0, '0, 32'hE100_0001, 1'b0);

    repeat (5) @(negedge clk);
    check("resp_q_empty", 64'(resp_q.size()), 64'(0));
    check("mem_q_empty", 64'(mem_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
